// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32 control path: FSM states, ALU codes,
// opcodes, datapath mux selects and the per-state control word.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_FAULT    = 4'd11
  } state_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic       retire;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    aluop_e     alu_op;
  } ctrl_t;

  // Immediate format depends only on the opcode, independent of FSM state.
  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU operation select: fixed add/sub for address and branch work, funct3/funct7
// decode for R- and I-type arithmetic.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] ALUOp,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] ALUControl
);

  always_comb begin
    ALUControl = ALU_ADD;
    case (ALUOp)
      ALUOP_SUB: ALUControl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // op5 separates R-type from I-type: addi never subtracts even if bit 30 is set
          3'b000:  ALUControl = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  ALUControl = ALU_SLT;
          3'b110:  ALUControl = ALU_OR;
          3'b111:  ALUControl = ALU_AND;
          default: ALUControl = ALU_ADD;
        endcase
      end
      default: ALUControl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32 subset controller: state register plus Moore-style control decode,
// with memory handshake stalls in FETCH, MEMREAD and MEMWRITE.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int WAIT_MEM = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       retire,
  output logic       illegal,
  output logic [3:0] state
);

  state_e state_q, state_d;
  ctrl_t  ctrl;
  logic   mem_rdy;

  assign mem_rdy = (WAIT_MEM == 0) ? 1'b1 : mem_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_rdy) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECR;
          OP_ITYPE:     state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_FAULT;
        endcase
      end
      S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_rdy) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_rdy) state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_BEQ:      state_d = S_FETCH;
      S_FAULT:    state_d = S_FAULT;
      default:    state_d = S_FAULT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Handshake-dependent strobes (FETCH, MEMWRITE, BEQ) must act in the same
  // cycle the condition is seen, so control is decoded from the state register.
  always_comb begin
    ctrl = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.result_src = RES_ALURESULT;
        ctrl.ir_write   = mem_rdy;
        ctrl.pc_write   = mem_rdy;
      end
      S_DECODE: begin
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: begin
        ctrl.adr_src    = 1'b1;
        ctrl.result_src = RES_ALUOUT;
      end
      S_MEMWB: begin
        ctrl.result_src = RES_DATA;
        ctrl.reg_write  = 1'b1;
        ctrl.retire     = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl.adr_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.retire    = mem_rdy;
      end
      S_EXECR: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_RS2;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_write  = 1'b1;
        ctrl.retire     = 1'b1;
      end
      S_JAL: begin
        ctrl.alu_src_a  = SRCA_OLDPC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.result_src = RES_ALUOUT;
        ctrl.pc_write   = 1'b1;
      end
      S_BEQ: begin
        ctrl.alu_src_a  = SRCA_RS1;
        ctrl.alu_src_b  = SRCB_RS2;
        ctrl.alu_op     = ALUOP_SUB;
        ctrl.result_src = RES_ALUOUT;
        ctrl.pc_write   = zero;
        ctrl.retire     = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

  alu_decoder u_alu_dec (
    .ALUOp      (ctrl.alu_op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .op5        (op[5]),
    .ALUControl (ALUControl)
  );

  // State is FETCH while reset is held; masking here keeps FETCH from strobing
  // IRWrite/PCWrite until reset is released.
  assign PCWrite   = ctrl.pc_write  & rst_n;
  assign IRWrite   = ctrl.ir_write  & rst_n;
  assign MemWrite  = ctrl.mem_write & rst_n;
  assign RegWrite  = ctrl.reg_write & rst_n;
  assign retire    = ctrl.retire    & rst_n;
  assign AdrSrc    = ctrl.adr_src;
  assign ResultSrc = ctrl.result_src;
  assign ALUSrcA   = ctrl.alu_src_a;
  assign ALUSrcB   = ctrl.alu_src_b;
  assign ImmSrc    = imm_src_of(op);
  assign illegal   = (state_q == S_FAULT);
  assign state     = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: stimulus queues expected per-cycle control
// vectors, an independent monitor pops and compares them against the DUT outputs.
module tb_multicycle_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, rst1_n, mem_ready, funct7b5, zero;
  logic [6:0] op;
  logic [2:0] funct3;

  logic       pcw0, adr0, irw0, mw0, rw0, ret0, ill0;
  logic [1:0] rs0, sa0, sb0, imm0;
  logic [2:0] aluc0;
  logic [3:0] st0;
  logic       pcw1, adr1, irw1, mw1, rw1, ret1, ill1;
  logic [1:0] rs1, sa1, sb1, imm1;
  logic [2:0] aluc1;
  logic [3:0] st1;

  multicycle_controller #(.WAIT_MEM(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready),
    .PCWrite(pcw0), .AdrSrc(adr0), .IRWrite(irw0), .MemWrite(mw0), .RegWrite(rw0),
    .ResultSrc(rs0), .ALUSrcA(sa0), .ALUSrcB(sb0), .ImmSrc(imm0),
    .ALUControl(aluc0), .retire(ret0), .illegal(ill0), .state(st0)
  );

  multicycle_controller #(.WAIT_MEM(0)) dut1 (
    .clk(clk), .rst_n(rst1_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(1'b0),
    .PCWrite(pcw1), .AdrSrc(adr1), .IRWrite(irw1), .MemWrite(mw1), .RegWrite(rw1),
    .ResultSrc(rs1), .ALUSrcA(sa1), .ALUSrcB(sb1), .ImmSrc(imm1),
    .ALUControl(aluc1), .retire(ret1), .illegal(ill1), .state(st1)
  );

  typedef struct packed {
    logic       sel;
    logic [3:0] st;
    logic [4:0] we;   // {PCWrite, IRWrite, MemWrite, RegWrite, retire}
    logic [2:0] alu;
    logic       ill;
    logic [1:0] imm;
  } exp_t;

  exp_t  q[$];
  string nq[$];
  int    checks = 0;
  int    failures = 0;
  event  sample_ev;

  // {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc} expected for each state
  function automatic logic [6:0] exp_mux(input logic [3:0] s);
    case (s)
      4'd0:    return 7'b0_00_10_10;
      4'd1:    return 7'b0_01_01_00;
      4'd2:    return 7'b0_10_01_00;
      4'd3:    return 7'b1_00_00_00;
      4'd4:    return 7'b0_00_00_01;
      4'd5:    return 7'b1_00_00_00;
      4'd6:    return 7'b0_10_00_00;
      4'd8:    return 7'b0_10_01_00;
      4'd9:    return 7'b0_01_10_00;
      4'd10:   return 7'b0_10_00_00;
      default: return 7'b0_00_00_00;
    endcase
  endfunction

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    case (o)
      7'b0100011: return 2'b01;
      7'b1100011: return 2'b10;
      7'b1101111: return 2'b11;
      default:    return 2'b00;
    endcase
  endfunction

  // {op, funct3, funct7b5, exec state, ALUControl}
  function automatic logic [17:0] rtab(input int i);
    case (i)
      0:       return {7'b0110011, 3'b000, 1'b0, 4'd6, 3'b000};
      1:       return {7'b0110011, 3'b000, 1'b1, 4'd6, 3'b001};
      2:       return {7'b0110011, 3'b111, 1'b0, 4'd6, 3'b010};
      3:       return {7'b0110011, 3'b110, 1'b0, 4'd6, 3'b011};
      4:       return {7'b0010011, 3'b010, 1'b0, 4'd8, 3'b101};
      5:       return {7'b0010011, 3'b000, 1'b1, 4'd8, 3'b000};
      default: return {7'b0110011, 3'b100, 1'b0, 4'd6, 3'b000};
    endcase
  endfunction

  task automatic chk(input string nm, input string fld, input logic [7:0] act, input logic [7:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s.%s actual=%0h expected=%0h", nm, fld, act, want);
    end
  endtask

  task automatic push(input logic sel, input logic [3:0] st, input logic [4:0] we,
                      input logic [2:0] alu, input string nm);
    exp_t e;
    e.sel = sel; e.st = st; e.we = we; e.alu = alu;
    e.ill = (st == 4'd11);
    e.imm = imm_of(op);
    q.push_back(e);
    nq.push_back(nm);
  endtask

  task automatic cyc(input logic sel, input logic [3:0] st, input logic [4:0] we,
                     input logic [2:0] alu, input string nm);
    push(sel, st, we, alu, nm);
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t       e;
    string      nm;
    logic [3:0] a_st;
    logic [4:0] a_we;
    logic [2:0] a_alu;
    logic [6:0] a_mux;
    logic       a_ill;
    logic [1:0] a_imm;
    forever begin
      @(negedge clk or sample_ev);
      if (q.size() > 0) begin
        e  = q.pop_front();
        nm = nq.pop_front();
        if (e.sel == 1'b0) begin
          a_st = st0; a_we = {pcw0, irw0, mw0, rw0, ret0}; a_alu = aluc0;
          a_mux = {adr0, sa0, sb0, rs0}; a_ill = ill0; a_imm = imm0;
        end else begin
          a_st = st1; a_we = {pcw1, irw1, mw1, rw1, ret1}; a_alu = aluc1;
          a_mux = {adr1, sa1, sb1, rs1}; a_ill = ill1; a_imm = imm1;
        end
        chk(nm, "state",   {4'd0, a_st},  {4'd0, e.st});
        chk(nm, "we",      {3'd0, a_we},  {3'd0, e.we});
        chk(nm, "alu",     {5'd0, a_alu}, {5'd0, e.alu});
        chk(nm, "mux",     {1'b0, a_mux}, {1'b0, exp_mux(e.st)});
        chk(nm, "illegal", {7'd0, a_ill}, {7'd0, e.ill});
        chk(nm, "imm",     {6'd0, a_imm}, {6'd0, e.imm});
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  logic [17:0] v;

  initial begin : stim
    rst_n = 1'b0; rst1_n = 1'b0; mem_ready = 1'b1;
    op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0;
    @(posedge clk); #1;
    cyc(0, 4'd0, 5'b00000, 3'b000, "rst_hold");
    rst_n = 1'b1;

    // R/I-type arithmetic: FETCH, DECODE, EXEC, ALUWB
    for (int i = 0; i < 7; i++) begin
      v = rtab(i);
      op = v[17:11]; funct3 = v[10:8]; funct7b5 = v[7];
      cyc(0, 4'd0, 5'b11000, 3'b000, "alu_fetch");
      cyc(0, 4'd1, 5'b00000, 3'b000, "alu_decode");
      cyc(0, v[6:3], 5'b00000, v[2:0], "alu_exec");
      cyc(0, 4'd7, 5'b00011, 3'b000, "alu_wb");
    end
    funct3 = 3'b000; funct7b5 = 1'b0;

    // lw with three MEMREAD wait cycles
    op = 7'b0000011; mem_ready = 1'b1;
    cyc(0, 4'd0, 5'b11000, 3'b000, "lw_fetch");
    cyc(0, 4'd1, 5'b00000, 3'b000, "lw_decode");
    cyc(0, 4'd2, 5'b00000, 3'b000, "lw_madr");
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc(0, 4'd3, 5'b00000, 3'b000, "lw_wait");
    mem_ready = 1'b1;
    cyc(0, 4'd3, 5'b00000, 3'b000, "lw_read");
    cyc(0, 4'd4, 5'b00011, 3'b000, "lw_wb");

    // sw with a FETCH stall and one MEMWRITE wait
    op = 7'b0100011; mem_ready = 1'b0;
    cyc(0, 4'd0, 5'b00000, 3'b000, "sw_fstall");
    mem_ready = 1'b1;
    cyc(0, 4'd0, 5'b11000, 3'b000, "sw_fetch");
    cyc(0, 4'd1, 5'b00000, 3'b000, "sw_decode");
    cyc(0, 4'd2, 5'b00000, 3'b000, "sw_madr");
    mem_ready = 1'b0;
    cyc(0, 4'd5, 5'b00100, 3'b000, "sw_wait");
    mem_ready = 1'b1;
    cyc(0, 4'd5, 5'b00101, 3'b000, "sw_done");

    // beq taken / not taken
    op = 7'b1100011; zero = 1'b1;
    cyc(0, 4'd0, 5'b11000, 3'b000, "beqt_fetch");
    cyc(0, 4'd1, 5'b00000, 3'b000, "beqt_decode");
    cyc(0, 4'd10, 5'b10001, 3'b001, "beq_taken");
    zero = 1'b0;
    cyc(0, 4'd0, 5'b11000, 3'b000, "beqn_fetch");
    cyc(0, 4'd1, 5'b00000, 3'b000, "beqn_decode");
    cyc(0, 4'd10, 5'b00001, 3'b001, "beq_nottaken");

    // jal
    op = 7'b1101111;
    cyc(0, 4'd0, 5'b11000, 3'b000, "jal_fetch");
    cyc(0, 4'd1, 5'b00000, 3'b000, "jal_decode");
    cyc(0, 4'd9, 5'b10000, 3'b000, "jal_exec");
    cyc(0, 4'd7, 5'b00011, 3'b000, "jal_wb");

    // illegal opcode: sticky FAULT until reset
    op = 7'b1111111;
    cyc(0, 4'd0, 5'b11000, 3'b000, "flt_fetch");
    cyc(0, 4'd1, 5'b00000, 3'b000, "flt_decode");
    for (int i = 0; i < 10; i++) cyc(0, 4'd11, 5'b00000, 3'b000, "fault_hold");
    rst_n = 1'b0;
    cyc(0, 4'd0, 5'b00000, 3'b000, "flt_reset");
    rst_n = 1'b1; op = 7'b0110011;
    cyc(0, 4'd0, 5'b11000, 3'b000, "post_flt_fetch");
    cyc(0, 4'd1, 5'b00000, 3'b000, "post_flt_decode");
    cyc(0, 4'd6, 5'b00000, 3'b000, "post_flt_exec");
    cyc(0, 4'd7, 5'b00011, 3'b000, "post_flt_wb");

    // asynchronous reset while MEMWRITE waits: checked between clock edges
    op = 7'b0100011; mem_ready = 1'b1;
    cyc(0, 4'd0, 5'b11000, 3'b000, "arst_fetch");
    cyc(0, 4'd1, 5'b00000, 3'b000, "arst_decode");
    cyc(0, 4'd2, 5'b00000, 3'b000, "arst_madr");
    mem_ready = 1'b0;
    push(0, 4'd5, 5'b00100, 3'b000, "arst_mwait");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    push(0, 4'd0, 5'b00000, 3'b000, "arst_now");
    ->sample_ev;
    @(posedge clk); #1;
    cyc(0, 4'd0, 5'b00000, 3'b000, "arst_hold");
    rst_n = 1'b1;
    cyc(0, 4'd0, 5'b00000, 3'b000, "arst_rel_stall");

    // WAIT_MEM=0 instance, mem_ready tied low: sw in four cycles
    op = 7'b0100011;
    cyc(1, 4'd0, 5'b00000, 3'b000, "w0_rst");
    rst1_n = 1'b1;
    cyc(1, 4'd0, 5'b11000, 3'b000, "w0_fetch");
    cyc(1, 4'd1, 5'b00000, 3'b000, "w0_decode");
    cyc(1, 4'd2, 5'b00000, 3'b000, "w0_madr");
    cyc(1, 4'd5, 5'b00101, 3'b000, "w0_mwrite");
    cyc(1, 4'd0, 5'b11000, 3'b000, "w0_next");

    @(posedge clk); @(posedge clk); #1;
    chk("drain", "queue", q.size()[7:0], 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
